// File: rtl/m65c02_mcycle_ctrl.sv
// Microcycle controller: stretches each microcycle to Len+1 clocks, inserts Ack wait states
// with optional timeout, and produces the sequencer Rdy enable plus Phi1O/Phi2O phases.
module m65c02_mcycle_ctrl #(
  parameter int pLenWidth  = 2,
  parameter int pMaxWait   = 15,
  parameter int pWaitWidth = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [pLenWidth-1:0] Len,
  input  logic                 Req,
  input  logic                 Ack,
  input  logic                 ClrTO,
  output logic                 Rdy,
  output logic                 Phi1O,
  output logic                 Phi2O,
  output logic [pLenWidth-1:0] CycCnt,
  output logic                 Busy,
  output logic                 WaitTO
);

  typedef enum logic [1:0] {sRST, sSTART, sCNT, sWAIT} state_t;

  localparam logic [pWaitWidth-1:0] MaxWaitC = pWaitWidth'(pMaxWait);
  // With the timeout disabled the counter still must not wrap, so it parks at all-ones.
  localparam logic [pWaitWidth-1:0] WaitSatC = (pMaxWait != 0) ? MaxWaitC : {pWaitWidth{1'b1}};
  localparam logic [pWaitWidth-1:0] WaitOneC = pWaitWidth'(1);
  localparam logic [pLenWidth-1:0]  LenOneC  = pLenWidth'(1);

  state_t                state_q, state_d;
  logic [pLenWidth-1:0]  len_q, len_d;
  logic                  req_q, req_d;
  logic [pLenWidth-1:0]  cyc_q, cyc_d;
  logic [pWaitWidth-1:0] wait_cnt_q, wait_cnt_d;
  logic                  wait_to_q, wait_to_d;

  logic terminal;
  logic eff_req;
  logic force_done;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    req_d      = req_q;
    cyc_d      = cyc_q;
    wait_cnt_d = wait_cnt_q;
    wait_to_d  = wait_to_q;
    terminal   = 1'b0;
    eff_req    = req_q;
    force_done = 1'b0;
    Rdy        = 1'b0;
    Busy       = 1'b0;
    Phi2O      = 1'b0;
    CycCnt     = '0;

    unique case (state_q)
      sRST: begin
        state_d    = sSTART;
        len_d      = '0;
        req_d      = 1'b0;
        cyc_d      = '0;
        wait_cnt_d = '0;
      end
      sSTART: begin
        len_d   = Len;
        req_d   = Req;
        eff_req = Req;
        CycCnt  = Len;
        Phi2O   = (Len <= (Len >> 1));
        if (Len == '0) begin
          terminal = 1'b1;
        end else begin
          cyc_d   = Len - LenOneC;
          state_d = sCNT;
        end
      end
      sCNT: begin
        CycCnt = cyc_q;
        Phi2O  = (cyc_q <= (len_q >> 1));
        if (cyc_q == '0) terminal = 1'b1;
        else             cyc_d    = cyc_q - LenOneC;
      end
      sWAIT: begin
        Busy  = 1'b1;
        Phi2O = 1'b1;
        if (Ack) begin
          Rdy = 1'b1;
        end else if ((pMaxWait != 0) && (wait_cnt_q == MaxWaitC)) begin
          Rdy        = 1'b1;
          force_done = 1'b1;
        end else if (wait_cnt_q != WaitSatC) begin
          wait_cnt_d = wait_cnt_q + WaitOneC;
        end
        if (Rdy) state_d = sSTART;
      end
      default: state_d = sRST;
    endcase

    if (terminal) begin
      if (!eff_req || Ack) begin
        Rdy     = 1'b1;
        state_d = sSTART;
      end else begin
        state_d    = sWAIT;
        wait_cnt_d = WaitOneC;
      end
    end

    if (force_done)  wait_to_d = 1'b1;
    else if (ClrTO)  wait_to_d = 1'b0;

    // Reset abandons the microcycle in the same clock: no Rdy may escape to the sequencer.
    if (Rst) begin
      Rdy        = 1'b0;
      state_d    = sRST;
      len_d      = '0;
      req_d      = 1'b0;
      cyc_d      = '0;
      wait_cnt_d = '0;
      wait_to_d  = 1'b0;
    end
  end

  assign Phi1O  = ~Phi2O;
  assign WaitTO = wait_to_q;

  always_ff @(posedge Clk) begin
    state_q    <= state_d;
    len_q      <= len_d;
    req_q      <= req_d;
    cyc_q      <= cyc_d;
    wait_cnt_q <= wait_cnt_d;
    wait_to_q  <= wait_to_d;
  end

endmodule

// File: tb/tb_m65c02_mcycle_ctrl.sv
// Directed bench for m65c02_mcycle_ctrl: vector table plus hand sequences for timeout and reset abort.
module tb_m65c02_mcycle_ctrl;

  logic       Clk = 1'b0;
  logic       Rst, Req, Ack, ClrTO;
  logic [1:0] Len;
  logic       Rdy, Phi1O, Phi2O, Busy, WaitTO;
  logic [1:0] CycCnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  m65c02_mcycle_ctrl #(.pLenWidth(2), .pMaxWait(15), .pWaitWidth(4)) dut (
    .Clk(Clk), .Rst(Rst), .Len(Len), .Req(Req), .Ack(Ack), .ClrTO(ClrTO),
    .Rdy(Rdy), .Phi1O(Phi1O), .Phi2O(Phi2O), .CycCnt(CycCnt), .Busy(Busy), .WaitTO(WaitTO)
  );

  // Expected output packing: {Rdy, Phi1O, Phi2O, CycCnt[1:0], Busy, WaitTO}
  typedef struct {
    string      nm;
    logic       rst;
    logic [1:0] len;
    logic       req;
    logic       ack;
    logic       clr;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [6:0] ex(logic rdy, logic p1, logic p2, logic [1:0] cc, logic bsy, logic to);
    return {rdy, p1, p2, cc, bsy, to};
  endfunction

  task automatic add(string nm, logic rst, logic [1:0] len, logic req, logic ack, logic clr, logic [6:0] e);
    vec_t v;
    v.nm = nm; v.rst = rst; v.len = len; v.req = req; v.ack = ack; v.clr = clr; v.exp = e;
    tbl.push_back(v);
  endtask

  // Drive one clock of inputs, compare at the falling edge, then move past the next rising edge.
  task automatic step(string nm, logic rst, logic [1:0] len, logic req, logic ack, logic clr, logic [6:0] e);
    logic [6:0] got;
    Rst = rst; Len = len; Req = req; Ack = ack; ClrTO = clr;
    @(negedge Clk);
    got = {Rdy, Phi1O, Phi2O, CycCnt, Busy, WaitTO};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got {rdy,phi1,phi2,cyc,busy,to}=%b required %b", nm, got, e);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // reset, stretch clock
    for (int i = 0; i < 3; i++) add("rst_hold", 1, 0, 0, 0, 0, ex(0, 1, 0, 0, 0, 0));
    add("rst_stretch", 0, 0, 0, 1, 0, ex(0, 1, 0, 0, 0, 0));
    // Len=0, Req=0: Rdy every clock
    for (int i = 0; i < 3; i++) add("len0_free", 0, 0, 0, 0, 0, ex(1, 0, 1, 0, 0, 0));
    // Len=3, Req=0 twice; Len/Req/Ack wiggle mid-cycle must be ignored
    for (int r = 0; r < 2; r++) begin
      add("len3_c3", 0, 3, 0, 0, 0, ex(0, 1, 0, 3, 0, 0));
      add("len3_c2", 0, 0, 1, 1, 0, ex(0, 1, 0, 2, 0, 0));
      add("len3_c1", 0, 1, 1, 1, 0, ex(0, 0, 1, 1, 0, 0));
      add("len3_c0", 0, 3, 1, 0, 0, ex(1, 0, 1, 0, 0, 0));
    end
    // Len=1, Req=1, Ack on third wait clock; Ack in the start clock is ignored
    add("len1_start", 0, 1, 1, 1, 0, ex(0, 1, 0, 1, 0, 0));
    add("len1_term",  0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));
    add("len1_w1",    0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1, 0));
    add("len1_w2",    0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1, 0));
    add("len1_w3ack", 0, 0, 0, 1, 0, ex(1, 0, 1, 0, 1, 0));
    // Len=0, Req=1 with Ack present: completes immediately
    add("len0_req_ack", 0, 0, 1, 1, 0, ex(1, 0, 1, 0, 0, 0));
    // Len=2, Req=0
    add("len2_c2", 0, 2, 0, 0, 0, ex(0, 1, 0, 2, 0, 0));
    add("len2_c1", 0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0));
    add("len2_c0", 0, 0, 0, 0, 0, ex(1, 0, 1, 0, 0, 0));

    Rst = 1'b1; Len = '0; Req = 1'b0; Ack = 1'b0; ClrTO = 1'b0;
    foreach (tbl[i]) step(tbl[i].nm, tbl[i].rst, tbl[i].len, tbl[i].req, tbl[i].ack, tbl[i].clr, tbl[i].exp);

    // Timeout: Len=0, Req=1, no Ack -> forced Rdy on 16th clock, WaitTO next clock
    step("to_start", 0, 0, 1, 0, 0, ex(0, 0, 1, 0, 0, 0));
    for (int i = 1; i < 15; i++) step("to_wait", 0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1, 0));
    step("to_force", 0, 0, 0, 0, 0, ex(1, 0, 1, 0, 1, 0));
    step("to_sticky", 0, 0, 0, 0, 0, ex(1, 0, 1, 0, 0, 1));
    step("to_clr_clk", 0, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 1));
    step("to_cleared", 0, 0, 0, 0, 0, ex(1, 0, 1, 0, 0, 0));

    // Set beats ClrTO when both land in the same clock
    step("to2_start", 0, 0, 1, 0, 0, ex(0, 0, 1, 0, 0, 0));
    for (int i = 1; i < 15; i++) step("to2_wait", 0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1, 0));
    step("to2_force_clr", 0, 0, 0, 0, 1, ex(1, 0, 1, 0, 1, 0));
    step("to2_set_wins", 0, 0, 0, 0, 0, ex(1, 0, 1, 0, 0, 1));

    // Reset during second wait clock of a Len=2 Req=1 cycle: no Rdy, clean restart
    step("ra_c2",    0, 2, 1, 0, 1, ex(0, 1, 0, 2, 0, 1));
    step("ra_c1",    0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0));
    step("ra_c0",    0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));
    step("ra_w1",    0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1, 0));
    step("ra_w2rst", 1, 0, 0, 1, 0, ex(0, 0, 1, 0, 1, 0));
    step("ra_rst",   0, 0, 0, 1, 0, ex(0, 1, 0, 0, 0, 0));
    step("ra_n_c2",  0, 2, 0, 0, 0, ex(0, 1, 0, 2, 0, 0));
    step("ra_n_c1",  0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0));
    step("ra_n_c0",  0, 0, 0, 0, 0, ex(1, 0, 1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
